mon_prod_rk: RTL

Parametrised radix-2^K Montgomery product engine, the successor of the fixed 1024-bit radix-2 multiplier. It computes P = A·B·R^-1 mod M with R = 2^BITLEN, consuming K bits of B per cycle. Operands are read from the shared word-addressed operand RAM and the result is written back to it. It sits between the exponentiation sequencer (which drives start/op_code and waits for done) and the operand RAM.

---
 rtl/mon_prod_rk.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mon_prod_rk.sv
`default_nettype none
// ============================================================================
// Module   : mon_prod_rk
// Purpose  : Radix-2^K Montgomery product engine. Computes
//            P = A*B*R^-1 mod M, R = 2^BITLEN, consuming K bits of B per
//            CALC cycle. Operands come from the word-addressed operand RAM
//            and the result is optionally written back over x_bar.
// Ports    : clk, rst          - clock / synchronous active-high reset
//            start, op_code    - operation request from the sequencer
//            M, m_inv          - modulus and -M^-1 mod 2^K (stable while busy)
//            rd_addr, rd_data  - RAM read port (data one cycle after address)
//            wr_addr, wr_data,
//            wr_en             - RAM write port (result write-back)
//            busy, done        - status; done is a one-cycle pulse
//            P                 - result, held until the next operation ends
// Options  : MON_PROD_WB_EN defined   -> STORE state writes P back to RAM.
//            MON_PROD_WB_EN undefined -> no write-back, write port tied to 0.
// Revision : 1.0 - initial radix-2^K release
// ============================================================================
module mon_prod_rk #(
  parameter int BITLEN = 1024,
  parameter int DBITS  = 512,
  parameter int ABITS  = 8,
  parameter int K      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op_code,
  input  logic [BITLEN-1:0] M,
  input  logic [K-1:0]      m_inv,
  output logic [ABITS-1:0]  rd_addr,
  input  logic [DBITS-1:0]  rd_data,
  output logic [ABITS-1:0]  wr_addr,
  output logic [DBITS-1:0]  wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic [BITLEN-1:0] P
);

  localparam int c_NWORDS = BITLEN / DBITS;
  localparam int c_ITER   = BITLEN / K;
  // Accumulator width: Pacc < 2M plus b*A plus q*M stays below 2^(BITLEN+K+1).
  localparam int c_W      = BITLEN + K + 1;
  localparam int c_CW     = $clog2(c_ITER + 2*c_NWORDS + 2);

  localparam logic [1:0] c_OPXX = 2'd0;
  localparam logic [1:0] c_OPXM = 2'd1;
  localparam logic [1:0] c_OPX1 = 2'd2;
  localparam logic [1:0] c_OPMM = 2'd3;

  localparam logic [c_CW-1:0] c_ITER_LAST = c_CW'(c_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CALC   = 3'd2,
    S_REDUCE = 3'd3,
    S_STORE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            r_state, w_state;
  logic [1:0]        r_op, w_op;
  logic [c_CW-1:0]   r_cnt, w_cnt;
  logic [BITLEN-1:0] r_a, w_a;
  logic [BITLEN-1:0] r_b, w_b;
  logic [c_W-1:0]    r_acc, w_acc;
  logic [BITLEN-1:0] r_p, w_p;
  logic [ABITS-1:0]  r_rd_addr, w_rd_addr;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
`ifdef MON_PROD_WB_EN
  logic [ABITS-1:0]  r_wr_addr, w_wr_addr;
  logic [DBITS-1:0]  r_wr_data, w_wr_data;
  logic              r_wr_en, w_wr_en;
`endif

  // One radix-2^K Montgomery step on the accumulator.
  logic [K-1:0]    w_bd;
  logic [c_W-1:0]  w_t;
  logic [K-1:0]    w_q;
  logic [c_W-1:0]  w_u;
  logic [c_W-1:0]  w_step;
  logic [c_W-1:0]  w_mext;
  logic [c_W-1:0]  w_red;
  logic [c_CW-1:0] w_len;

  assign w_mext = {{(K+1){1'b0}}, M};
  assign w_bd   = r_b[K-1:0];
  assign w_t    = r_acc + ({{(c_W-K){1'b0}}, w_bd} * {{(K+1){1'b0}}, r_a});
  // Truncation to K bits is the mod 2^K.
  assign w_q    = w_t[K-1:0] * m_inv;
  assign w_u    = w_t + ({{(c_W-K){1'b0}}, w_q} * w_mext);
  assign w_step = w_u >> K;
  assign w_red  = (r_acc >= w_mext) ? (r_acc - w_mext) : r_acc;
  // OPXM streams x_bar then M_bar, all others read a single operand.
  assign w_len  = (r_op == c_OPXM) ? c_CW'(2*c_NWORDS) : c_CW'(c_NWORDS);

  always_comb begin
    w_state   = r_state;
    w_op      = r_op;
    w_cnt     = r_cnt;
    w_a       = r_a;
    w_b       = r_b;
    w_acc     = r_acc;
    w_p       = r_p;
    w_rd_addr = r_rd_addr;
    w_busy    = r_busy;
    w_done    = 1'b0;
`ifdef MON_PROD_WB_EN
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    w_wr_en   = r_wr_en;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_op      = op_code;
          w_busy    = 1'b1;
          w_rd_addr = (op_code == c_OPMM) ? ABITS'(c_NWORDS) : '0;
          w_acc     = '0;
          w_cnt     = '0;
          w_b       = (op_code == c_OPX1) ? BITLEN'(1) : '0;
          w_state   = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cnt = r_cnt + c_CW'(1);
        if ((r_cnt + c_CW'(1)) < w_len) begin
          w_rd_addr = r_rd_addr + ABITS'(1);
        end
        // Word j arrives on the edge where r_cnt == j+1.
        for (int i = 0; i < c_NWORDS; i++) begin
          if (r_cnt == c_CW'(i + 1)) begin
            w_a[i*DBITS +: DBITS] = rd_data;
            if (r_op == c_OPXX || r_op == c_OPMM) begin
              w_b[i*DBITS +: DBITS] = rd_data;
            end
          end
          if (r_op == c_OPXM && r_cnt == c_CW'(i + 1 + c_NWORDS)) begin
            w_b[i*DBITS +: DBITS] = rd_data;
          end
        end
        if (r_cnt == w_len) begin
          w_cnt   = '0;
          w_state = S_CALC;
        end
      end
      S_CALC: begin
        w_acc = w_step;
        w_b   = r_b >> K;
        w_cnt = r_cnt + c_CW'(1);
        if (r_cnt == c_ITER_LAST) begin
          w_cnt   = '0;
          w_state = S_REDUCE;
        end
      end
      S_REDUCE: begin
        w_acc = w_red;
        w_p   = w_red[BITLEN-1:0];
`ifdef MON_PROD_WB_EN
        w_wr_en   = 1'b1;
        w_wr_addr = '0;
        w_wr_data = w_red[DBITS-1:0];
        w_cnt     = '0;
        w_state   = S_STORE;
`else
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_DONE;
`endif
      end
`ifdef MON_PROD_WB_EN
      S_STORE: begin
        if (r_cnt == c_CW'(c_NWORDS - 1)) begin
          w_wr_en = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end else begin
          w_cnt     = r_cnt + c_CW'(1);
          w_wr_addr = r_wr_addr + ABITS'(1);
          for (int i = 1; i < c_NWORDS; i++) begin
            if (r_cnt == c_CW'(i - 1)) begin
              w_wr_data = r_p[i*DBITS +: DBITS];
            end
          end
        end
      end
`endif
      // The done cycle sits outside IDLE so a start held here is ignored.
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_p       <= '0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MON_PROD_WB_EN
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_op      <= w_op;
      r_cnt     <= w_cnt;
      r_a       <= w_a;
      r_b       <= w_b;
      r_acc     <= w_acc;
      r_p       <= w_p;
      r_rd_addr <= w_rd_addr;
      r_busy    <= w_busy;
      r_done    <= w_done;
`ifdef MON_PROD_WB_EN
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_wr_en   <= w_wr_en;
`endif
    end
  end

  assign rd_addr = r_rd_addr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign P       = r_p;
`ifdef MON_PROD_WB_EN
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign wr_en   = r_wr_en;
`else
  assign wr_addr = '0;
  assign wr_data = '0;
  assign wr_en   = 1'b0;
`endif

endmodule
`default_nettype wire
